// File: rtl/spi_pkg.sv
// Shared types and helpers for the burst SPI slave: FSM state encoding,
// frame direction constants and the SCK edge-polarity helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } spi_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // The sample edge is the leading edge (away from CPOL) when CPHA = 0 and
  // the trailing edge when CPHA = 1. That works out to "sample on the rising
  // edge" exactly when CPOL and CPHA are equal. The shift edge is the other one.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings sck/ncs/si into the clk domain through 2-FF synchronisers and
// produces registered, single-cycle edge pulses. si_s is delayed one more
// stage so that it lines up with the registered sck pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ncs,
  input  logic si,
  output logic sck_sample,
  output logic sck_shift,
  output logic ncs_fall,
  output logic ncs_rise,
  output logic si_s
);

  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  // [0],[1] are the synchroniser pair; [2] is the previous value used for edge detection
  logic [2:0] sck_q;
  logic [2:0] ncs_q;
  logic [1:0] si_q;
  logic       sck_rise;
  logic       sck_fall;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];

  // Synchroniser chains; sck resets to its idle level so reset release makes no false edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q <= {3{CPOL}};
      ncs_q <= 3'b111;
      si_q  <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ncs_q <= {ncs_q[1:0], ncs};
      si_q  <= {si_q[0], si};
    end
  end

  // Registered edge pulses and the aligned data bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sample <= 1'b0;
      sck_shift  <= 1'b0;
      ncs_fall   <= 1'b0;
      ncs_rise   <= 1'b0;
      si_s       <= 1'b0;
    end else begin
      sck_sample <= SAMPLE_RISE ? sck_rise : sck_fall;
      sck_shift  <= SAMPLE_RISE ? sck_fall : sck_rise;
      ncs_fall   <= ~ncs_q[1] & ncs_q[2];
      ncs_rise   <= ncs_q[1] & ~ncs_q[2];
      si_s       <= si_q[1];
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave for the MCU register bus. A frame is [rw, addr, word0, word1, ...]
// MSB first and ends when ncs rises. Writes produce one wr_en per word; reads
// issue rd_req per word and shift the returned rd_data out on MISO.
// Read handshake: rd_req is a one-cycle request for the current addr; the first
// clk with rd_valid = 1 after it supplies rd_data. Data that has not arrived by
// the shift edge of the word's first bit is an underrun: the word goes out as
// zeros and err_underrun is set until the next frame starts.
module spi_slave_burst
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 24,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ncs,
  input  logic                  si,
  output logic                  so,
  output logic                  so_oe,
  output logic                  rw,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  busy,
  output logic                  err_underrun,
  output logic [1:0]            dbg_state
);

  localparam int unsigned SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CW = $clog2(SW + 2);

  logic sck_sample;
  logic sck_shift;
  logic ncs_fall;
  logic ncs_rise;
  logic si_s;

  spi_sync_edge #(
    .CPOL(CPOL),
    .CPHA(CPHA)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .ncs       (ncs),
    .si        (si),
    .sck_sample(sck_sample),
    .sck_shift (sck_shift),
    .ncs_fall  (ncs_fall),
    .ncs_rise  (ncs_rise),
    .si_s      (si_s)
  );

  spi_state_e          state;
  spi_state_e          state_nx;
  logic                hdr_done;
  logic                word_done;
  logic                frame_start;
  logic                frame_end;
  logic [CW-1:0]       bit_cnt;
  logic [SW-1:0]       shift_reg;
  logic [SW-1:0]       shift_nx;
  logic [DATA_WIDTH-1:0] tx;
  logic                tx_loaded;
  logic                tx_first;
  logic                rd_wait;
  logic                rd_pend;
  logic                inc_pend;
  logic                rx_bit;

  assign shift_nx  = {shift_reg[SW-2:0], si_s};
  assign dbg_state = state;
  // A sample edge counts only inside a frame and only if ncs is not rising at the same time
  assign rx_bit    = sck_sample && (state != IDLE) && !frame_end;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and frame event decode; ncs rising takes priority over any sample
  always_comb begin
    state_nx    = state;
    hdr_done    = 1'b0;
    word_done   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          state_nx    = HDR;
          frame_start = 1'b1;
        end
      end
      HDR: begin
        if (ncs_rise) begin
          state_nx  = IDLE;
          frame_end = 1'b1;
        end else if (sck_sample && bit_cnt == CW'(ADDR_WIDTH)) begin
          hdr_done = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (ncs_rise) begin
          state_nx  = IDLE;
          frame_end = 1'b1;
        end else if (sck_sample && bit_cnt == CW'(DATA_WIDTH - 1)) begin
          word_done = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Receive side: bit counter, shift register and the direction bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      rw        <= 1'b0;
    end else begin
      if (frame_start || hdr_done || word_done) bit_cnt <= '0;
      else if (rx_bit)                         bit_cnt <= bit_cnt + CW'(1);
      if (rx_bit) shift_reg <= shift_nx;
      if (rx_bit && state == HDR && bit_cnt == '0) rw <= si_s;
    end
  end

  // Bus side and MISO: address sequencing, strobes, read handshake, tx shifting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr         <= '0;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      rd_req       <= 1'b0;
      busy         <= 1'b0;
      so_oe        <= 1'b0;
      so           <= 1'b0;
      err_underrun <= 1'b0;
      tx           <= '0;
      tx_loaded    <= 1'b0;
      tx_first     <= 1'b0;
      rd_wait      <= 1'b0;
      rd_pend      <= 1'b0;
      inc_pend     <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      rd_req <= 1'b0;

      if (hdr_done) begin
        addr     <= shift_nx[ADDR_WIDTH-1:0];
        rd_pend  <= (rw == RW_READ);
        tx_first <= 1'b1;
      end

      // addr stays put during the wr_en cycle; the increment follows one cycle later
      if (word_done) begin
        if (rw == RW_WRITE) begin
          wr_en   <= 1'b1;
          wr_data <= shift_nx[DATA_WIDTH-1:0];
        end
        inc_pend <= 1'b1;
        tx_first <= 1'b1;
      end

      if (inc_pend) begin
        addr     <= addr + ADDR_WIDTH'(AUTO_INC);
        inc_pend <= 1'b0;
        rd_pend  <= (rw == RW_READ) && (state == DATA);
      end

      if (rd_pend) begin
        rd_req    <= 1'b1;
        rd_wait   <= 1'b1;
        tx_loaded <= 1'b0;
        rd_pend   <= 1'b0;
      end

      // First bit of a word: use loaded data, or rd_data arriving this very cycle, else underrun
      if (state == DATA && rw == RW_READ && sck_shift) begin
        if (tx_first) begin
          tx_first  <= 1'b0;
          rd_wait   <= 1'b0;
          tx_loaded <= 1'b0;
          if (tx_loaded) begin
            so <= tx[DATA_WIDTH-1];
            tx <= {tx[DATA_WIDTH-2:0], 1'b0};
          end else if (rd_wait && rd_valid) begin
            so <= rd_data[DATA_WIDTH-1];
            tx <= {rd_data[DATA_WIDTH-2:0], 1'b0};
          end else begin
            so           <= 1'b0;
            tx           <= '0;
            err_underrun <= 1'b1;
          end
        end else begin
          so <= tx[DATA_WIDTH-1];
          tx <= {tx[DATA_WIDTH-2:0], 1'b0};
        end
      end else if (rd_wait && rd_valid && tx_first) begin
        tx        <= rd_data;
        tx_loaded <= 1'b1;
        rd_wait   <= 1'b0;
      end

      if (frame_start) begin
        busy         <= 1'b1;
        so_oe        <= 1'b1;
        so           <= 1'b0;
        err_underrun <= 1'b0;
        tx_loaded    <= 1'b0;
        tx_first     <= 1'b0;
        rd_wait      <= 1'b0;
        rd_pend      <= 1'b0;
      end

      // End of frame: partial word dropped, addr and rw keep their values
      if (frame_end) begin
        busy      <= 1'b0;
        so_oe     <= 1'b0;
        so        <= 1'b0;
        tx_loaded <= 1'b0;
        tx_first  <= 1'b0;
        rd_wait   <= 1'b0;
        rd_pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: one instance per SPI mode (index = CPOL*2 + CPHA),
// a table of write frames applied to every mode, and hand-written sequences
// for read, underrun, aborted frame and mid-frame reset.
module tb_spi_slave_burst;

  localparam int HALF = 6;

  typedef struct {
    int          mode;
    logic [63:0] bits;
    int          nbits;
    int          n_wr;
    logic [30:0] w0;
    logic [30:0] w1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sck;
  logic [3:0]  ncs;
  logic        si;
  logic [3:0]  so, so_oe, rw, wr_en, rd_req, busy, err_u, rd_valid;
  logic [23:0] rd_data;
  logic [6:0]  addr_a [4];
  logic [23:0] wr_data_a [4];
  logic [1:0]  dbg_a [4];

  int          n_vec = 0;
  int          n_miss = 0;
  int          cur_m = 0;
  bit          resp_en = 1'b0;
  bit          resp_pend = 1'b0;
  logic [23:0] resp_word = '0;
  int          rdreq_cnt = 0;
  logic [30:0] exp_q[$];
  logic [30:0] got_q[$];
  logic [6:0]  rd_addr_q[$];
  vec_t        vt [4];
  logic [63:0] rx;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit P = (g >= 2);
    localparam bit H = (g % 2 == 1);
    spi_slave_burst #(
      .ADDR_WIDTH(7),
      .DATA_WIDTH(24),
      .CPOL(P),
      .CPHA(H),
      .AUTO_INC(1'b1)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .sck         (sck[g]),
      .ncs         (ncs[g]),
      .si          (si),
      .so          (so[g]),
      .so_oe       (so_oe[g]),
      .rw          (rw[g]),
      .addr        (addr_a[g]),
      .wr_en       (wr_en[g]),
      .wr_data     (wr_data_a[g]),
      .rd_req      (rd_req[g]),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid[g]),
      .busy        (busy[g]),
      .err_underrun(err_u[g]),
      .dbg_state   (dbg_a[g])
    );
  end

  // Register-file model and write monitor for the mode under test
  initial begin
    rd_valid = '0;
    rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_valid = '0;
      if (resp_pend) begin
        rd_valid[cur_m] = 1'b1;
        resp_pend = 1'b0;
      end
      if (rd_req[cur_m]) begin
        rdreq_cnt++;
        rd_addr_q.push_back(addr_a[cur_m]);
        if (resp_en) begin
          resp_pend = 1'b1;
          rd_data   = resp_word;
        end
      end
      if (wr_en[cur_m]) got_q.push_back({addr_a[cur_m], wr_data_a[cur_m]});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [37:0] outs(input int m);
    return {so[m], so_oe[m], rw[m], addr_a[m], wr_en[m], wr_data_a[m], rd_req[m], busy[m], err_u[m]};
  endfunction

  // SPI master: one complete frame, MSB first; MISO captured on every sample edge
  task automatic frame(input int m, input logic [63:0] bits, input int nbits, output logic [63:0] rxd);
    logic cpol;
    logic cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rxd  = '0;
    sck[m] = cpol;
    ncs[m] = 1'b0;
    wait_clk(2 * HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        si = bits[i];
        wait_clk(HALF);
        rxd = {rxd[62:0], so[m]};
        sck[m] = ~cpol;
        wait_clk(HALF);
        sck[m] = cpol;
      end else begin
        sck[m] = ~cpol;
        si = bits[i];
        wait_clk(HALF);
        rxd = {rxd[62:0], so[m]};
        sck[m] = cpol;
        wait_clk(HALF);
      end
    end
    wait_clk(HALF);
    ncs[m] = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic check_wr(input string name);
    logic [30:0] e;
    logic [30:0] g;
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 31'h7FFF_FFFF;
      check({name, "_word"}, 64'(g), 64'(e));
    end
  endtask

  initial begin
    vt[0] = '{0, 64'({1'b0, 7'h05, 24'hA5A5A5}), 32, 1, {7'h05, 24'hA5A5A5}, 31'h0};
    vt[1] = '{3, 64'({1'b0, 7'h7F, 24'h000001, 24'h000002}), 56, 2, {7'h7F, 24'h000001}, {7'h00, 24'h000002}};
    vt[2] = '{1, 64'({1'b0, 7'h33, 24'h5A0FF0}), 32, 1, {7'h33, 24'h5A0FF0}, 31'h0};
    vt[3] = '{2, 64'({1'b0, 7'h01, 24'hFFFFFE, 24'h800001}), 56, 2, {7'h01, 24'hFFFFFE}, {7'h02, 24'h800001}};

    // Clock/reset block
    rst = 1'b0;
    sck = 4'b1100;
    ncs = 4'hF;
    si  = 1'b0;
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("reset_outs_m%0d", m), 64'(outs(m)), 64'h0);
      check($sformatf("reset_state_m%0d", m), 64'(dbg_a[m]), 64'h0);
    end
    rst = 1'b1;
    wait_clk(5);

    // Mid-frame reset in mode 2: header of all ones makes it a read in progress
    cur_m   = 2;
    resp_en = 1'b0;
    ncs[2]  = 1'b0;
    wait_clk(2 * HALF);
    for (int i = 0; i < 12; i++) begin
      si = 1'b1;
      wait_clk(HALF);
      sck[2] = 1'b0;
      wait_clk(HALF);
      sck[2] = 1'b1;
    end
    wait_clk(HALF);
    check("midframe_busy", 64'(busy[2]), 64'h1);
    check("midframe_rw", 64'(rw[2]), 64'h1);
    check("midframe_state", 64'(dbg_a[2]), 64'h2);
    rst = 1'b0;
    #1;
    check("async_reset_outs", 64'(outs(2)), 64'h0);
    check("async_reset_state", 64'(dbg_a[2]), 64'h0);
    ncs[2] = 1'b1;
    si = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(10);

    // Table of write frames covering every CPOL/CPHA combination
    for (int i = 0; i < 4; i++) begin
      cur_m = vt[i].mode;
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(vt[i].w0);
      if (vt[i].n_wr > 1) exp_q.push_back(vt[i].w1);
      frame(vt[i].mode, vt[i].bits, vt[i].nbits, rx);
      check_wr($sformatf("vec%0d", i));
      check($sformatf("vec%0d_busy", i), 64'(busy[vt[i].mode]), 64'h0);
      check($sformatf("vec%0d_state", i), 64'(dbg_a[vt[i].mode]), 64'h0);
      check($sformatf("vec%0d_so_oe", i), 64'(so_oe[vt[i].mode]), 64'h0);
    end

    // Mode 1 read of 0x10 with data returned one clk after rd_req
    cur_m     = 1;
    resp_en   = 1'b1;
    resp_word = 24'h123456;
    rdreq_cnt = 0;
    rd_addr_q.delete();
    got_q.delete();
    frame(1, 64'({1'b1, 7'h10, 24'h000000}), 32, rx);
    check("read_miso", 64'(rx[23:0]), 64'h123456);
    check("read_hdr_zero", 64'(rx[31:24]), 64'h0);
    check("read_err", 64'(err_u[1]), 64'h0);
    check("read_rdreq_cnt", 64'(rdreq_cnt), 64'h2);
    check("read_addr0", 64'((rd_addr_q.size() > 0) ? rd_addr_q[0] : 7'h7F), 64'h10);
    check("read_addr1", 64'((rd_addr_q.size() > 1) ? rd_addr_q[1] : 7'h7F), 64'h11);
    check("read_no_wr", 64'(got_q.size()), 64'h0);

    // Mode 1 read with rd_valid withheld
    resp_en = 1'b0;
    frame(1, 64'({1'b1, 7'h20, 24'hFFFFFF}), 32, rx);
    check("underrun_miso", 64'(rx[23:0]), 64'h0);
    check("underrun_flag", 64'(err_u[1]), 64'h1);
    ncs[1] = 1'b0;
    wait_clk(8);
    check("underrun_cleared", 64'(err_u[1]), 64'h0);
    check("underrun_busy", 64'(busy[1]), 64'h1);
    ncs[1] = 1'b1;
    wait_clk(2 * HALF);
    check("underrun_idle", 64'(busy[1]), 64'h0);

    // Mode 0 write aborted after 10 data bits, then a complete frame
    cur_m = 0;
    got_q.delete();
    frame(0, 64'({1'b0, 7'h22, 10'h3FF}), 18, rx);
    check("abort_no_wr", 64'(got_q.size()), 64'h0);
    check("abort_state", 64'(dbg_a[0]), 64'h0);
    check("abort_addr_held", 64'(addr_a[0]), 64'h22);
    exp_q.delete();
    exp_q.push_back({7'h06, 24'h0F0F0F});
    frame(0, 64'({1'b0, 7'h06, 24'h0F0F0F}), 32, rx);
    check_wr("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
- Parametrised successor to the single-word soft SPI slave.
- Serves the MCU-to-FPGA register bus, sitting between the MCU SPI pins and the register file of the DSP chain.
- Adds all four SPI modes, configurable address and data widths, multi-word burst frames with address auto-increment, a 2-FF input synchroniser and a read-data handshake with underrun detection.
- Frame format, MSB first: [rw (1 bit), addr (ADDR_WIDTH bits), word0, word1, ...], each word DATA_WIDTH bits. The frame ends when ncs rises.

Parameters:
- ADDR_WIDTH, 7: register address width, >= 1.
- DATA_WIDTH, 24: word width, >= 2.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- AUTO_INC, 1: 1 = address increments after each word in a burst; 0 = address is held.

Ports:
- clk  in  1  system clock; must be >= 8x the SCK frequency.
- rst  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock (asynchronous).
- ncs  in  1  SPI chip select, active low (asynchronous).
- si  in  1  MOSI (asynchronous).
- so  out  1  MISO data.
- so_oe  out  1  MISO output enable (1 while selected).
- rw  out  1  frame direction; 1 = read, 0 = write.
- addr  out  ADDR_WIDTH  current word address.
- wr_en  out  1  one-cycle write strobe.
- wr_data  out  DATA_WIDTH  write data, valid while wr_en = 1.
- rd_req  out  1  one-cycle read request for addr.
- rd_data  in  DATA_WIDTH  read data.
- rd_valid  in  1  rd_data valid; sampled on a clk edge.
- busy  out  1  frame in progress (ncs low after synchronisation).
- err_underrun  out  1  sticky read-underrun flag; cleared at the start of the next frame.

Behaviour:
- Synchronisation:
  - sck, ncs and si each pass through 2 FFs; sck gets one extra delay stage for edge detection.
  - sample_edge = leading edge if CPHA = 0, trailing edge if CPHA = 1. Leading edge = transition away from the CPOL level. shift_edge is the opposite edge.
- Async reset (rst = 0), all outputs forced to: so = 0, so_oe = 0, rw = 0, addr = 0, wr_en = 0, wr_data = 0, rd_req = 0, busy = 0, err_underrun = 0. FSM goes to IDLE and all counters clear.
- FSM states and transitions:
  - IDLE: on synced ncs falling -> HDR. Clear the bit counter and err_underrun; set busy = 1 and so_oe = 1.
  - HDR: shift si in on each sample_edge. The first bit is latched into rw.
    - After 1 + ADDR_WIDTH samples: load addr.
    - If rw = 1: pulse rd_req for one cycle.
    - Go to DATA.
  - DATA: shift si in on each sample_edge, DATA_WIDTH bits per word.
    - At the last bit: if rw = 0, drive wr_data = assembled word and pulse wr_en for one clk, with addr valid in the same cycle.
    - Then addr <= addr + AUTO_INC, wrapping modulo 2^ADDR_WIDTH.
    - If rw = 1: pulse rd_req one cycle after the address update.
    - Stay in DATA.
- Synced ncs rising in any state -> IDLE, the same cycle it is detected.
  - A partially received word is discarded: no wr_en.
  - busy = 0, so_oe = 0, so = 0.
  - Address and rw hold their last value.
- Read path:
  - An internal tx register is loaded from rd_data on the first clk where rd_valid = 1 after rd_req. rd_valid is ignored at other times.
  - so is updated only on shift_edge in DATA with rw = 1, taking tx bits MSB first.
  - CPHA = 0: the first bit goes out on the shift_edge that ends the last header bit (or the last bit of the previous word).
  - CPHA = 1: the first bit goes out on the leading edge of the first data bit.
  - If the tx register is not loaded when the first bit must be driven: shift out zeros for that word and set err_underrun = 1.
  - During HDR and write frames: so = 0.
- Simultaneous events:
  - ncs rise and sample_edge in the same clk: ncs wins.
  - rd_valid arriving in the same clk as the shift_edge for the first bit: counts as in time.
- Timing:
  - wr_en asserts 1 clk after the final sample_edge is detected, i.e. 4 clk after the SCK pin edge.
  - rd_req asserts 1 clk after the header completes. rd_valid must arrive within 2 clk to be safe at the 8x clock ratio.

Decomposition:
- Package spi_pkg holds:
  - the FSM state enum (IDLE, HDR, DATA);
  - the function that derives sample/shift edge polarity from CPOL/CPHA;
  - the RW_READ / RW_WRITE constants.
- Sub-module spi_sync_edge: 2-FF synchroniser plus edge detector for sck/ncs/si. It outputs sck_sample, sck_shift, ncs_fall, ncs_rise and si_s.

Test Plan:
- Mode 0, write frame, bits 0 | 0x05 | 0xA5A5A5 -> one wr_en with addr = 0x05 and wr_data = 0xA5A5A5; busy falls after ncs rises.
- Mode 3, burst write to addr 0x7F with words 0x000001 and 0x000002, AUTO_INC = 1 -> two wr_en: (0x7F, 1), then (0x00, 2) because of the address wrap.
- Mode 1, read of addr 0x10, rd_data = 0x123456 returned 1 clk after rd_req -> MISO carries 0x123456 MSB first, err_underrun = 0; rd_req fires again after the word.
- Read with rd_valid withheld -> MISO carries 0x000000, err_underrun = 1; the flag clears at the next ncs falling edge.
- ncs raised after 10 data bits of a write -> no wr_en; FSM returns to IDLE; the next full frame works normally.
- Reset pulse mid-frame, plus a mode 2 sweep -> all outputs return to their reset values immediately; frames after reset decode correctly in every CPOL/CPHA combination.
